// File: rtl/mmio_led_timer.sv
// mmio_led_timer
//   Memory-mapped LED/timer peripheral that sits beside dmem on the core's
//   data bus. It provides a 16-byte register window with LED_DATA, MODE,
//   PERIOD and STATUS. The block rotates or blinks the LED pattern in
//   hardware on every timer tick, and it keeps a sticky tick flag.
//
// Ports
//   clk      : system clock; all state changes on the rising edge
//   reset    : asynchronous reset, active low
//   we       : store strobe (MemWrite)
//   addr     : byte address (DataAdr); addr[1:0] is ignored
//   wdata    : store data (WriteData); only full-word stores are supported
//   hit      : combinational; addr lies inside the register window
//   rdata    : combinational read data; 0 when !hit
//   led      : LED pins, driven from registered state only
//   tick_irq : level copy of STATUS.TICK
module mmio_led_timer #(
  parameter logic [31:0]      BASE_ADDR  = 32'h0000_0100,
  parameter int unsigned      CNT_W      = 24,
  parameter logic [CNT_W-1:0] RST_PERIOD = CNT_W'(50),
  parameter logic [7:0]       RST_LED    = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic [7:0]  led,
  output logic        tick_irq
);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_ROL    = 2'd1,
    MODE_ROR    = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  logic [7:0]       led_data_q, led_data_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             blink_q, blink_d;

  logic [1:0]       off;
  logic             wr_led, wr_mode, wr_period, wr_status;
  logic             tick;
  logic [CNT_W+7:0] status_w;
  logic             unused_bits;

  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  // Address decode
  assign hit = (addr[31:4] == BASE_ADDR[31:4]);
  assign off = addr[3:2];

  assign wr_led    = we && hit && (off == 2'd0);
  assign wr_mode   = we && hit && (off == 2'd1);
  assign wr_period = we && hit && (off == 2'd2);
  assign wr_status = we && hit && (off == 2'd3);

  // Bits that are deliberately ignored: the byte lane and the wdata bits
  // above the register widths.
  assign unused_bits = ^{addr[1:0], wdata};

  // A PERIOD or MODE write reloads the counter, so a tick cannot fire in
  // that write cycle.
  assign tick = (period_q != '0) && (cnt_q == '0) && !wr_period && !wr_mode;

  // Next-state logic
  always_comb begin
    led_data_d = led_data_q;
    mode_d     = mode_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    tick_d     = tick_q;
    blink_d    = blink_q;

    // Counter
    if (wr_period) begin
      period_d = wdata[CNT_W-1:0];
      cnt_d    = dec_sat(wdata[CNT_W-1:0]);
    end else if (wr_mode) begin
      cnt_d = dec_sat(period_q);
    end else if (period_q == '0) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = period_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // Mode and blink phase
    if (wr_mode) begin
      mode_d  = mode_e'(wdata[1:0]);
      blink_d = 1'b0;
    end else if (tick && (mode_q == MODE_BLINK)) begin
      blink_d = ~blink_q;
    end

    // LED pattern: a software write overrides the rotate of the same cycle
    if (wr_led) begin
      led_data_d = wdata[7:0];
    end else if (tick) begin
      unique case (mode_q)
        MODE_ROL: led_data_d = {led_data_q[6:0], led_data_q[7]};
        MODE_ROR: led_data_d = {led_data_q[0], led_data_q[7:1]};
        default:  led_data_d = led_data_q;
      endcase
    end

    // Sticky flag: a new tick wins over a W1C in the same cycle
    if (tick) begin
      tick_d = 1'b1;
    end else if (wr_status && wdata[0]) begin
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_data_q <= RST_LED;
      mode_q     <= MODE_STATIC;
      period_q   <= RST_PERIOD;
      cnt_q      <= RST_PERIOD;
      tick_q     <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      led_data_q <= led_data_d;
      mode_q     <= mode_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      blink_q    <= blink_d;
    end
  end

  // Read mux
  assign status_w = {cnt_q, 7'b0, tick_q};

  always_comb begin
    rdata = '0;
    if (hit) begin
      unique case (off)
        2'd0:    rdata = {24'b0, led_data_q};
        2'd1:    rdata = {30'b0, mode_q};
        2'd2:    rdata = 32'(period_q);
        default: rdata = 32'(status_w);
      endcase
    end
  end

  // Outputs
  assign led      = ((mode_q == MODE_BLINK) && blink_q) ? 8'h00 : led_data_q;
  assign tick_irq = tick_q;

endmodule

// File: tb/tb_mmio_led_timer.sv
// tb_mmio_led_timer
//   Directed bench for mmio_led_timer. All stimulus is applied 1 ns after
//   a rising edge, and all outputs are sampled there too. Expected values
//   are computed by hand from the register behaviour.
module tb_mmio_led_timer;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        hit;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic        tick_irq;
  logic        dmem_we;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mmio_led_timer #(
    .BASE_ADDR (32'h0000_0100),
    .CNT_W     (24),
    .RST_PERIOD(24'd50),
    .RST_LED   (8'h01)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .hit     (hit),
    .rdata   (rdata),
    .led     (led),
    .tick_irq(tick_irq)
  );

  // Integration glue as done in top: the window steals stores from dmem
  assign dmem_we = we && !hit;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called 1 ns after a rising edge; returns 1 ns after the capturing edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d    = rdata;
    addr = '0;
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  logic [7:0]  rol_exp [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check("rst_led", {24'b0, led}, 32'h01);
    check("rst_irq", {31'b0, tick_irq}, 32'h0);
    bus_read(32'h10C, rd);
    check("rst_status", rd, 32'h0000_3200);

    // Rotate-left, PERIOD=4
    bus_write(32'h108, 32'd4);
    bus_write(32'h104, 32'd1);
    for (int unsigned k = 0; k < 8; k++) begin
      step(3);
      check("rol_hold", {24'b0, led}, (k == 0) ? 32'h01 : {24'b0, rol_exp[k-1]});
      if (k == 0) check("rol_irq_pre", {31'b0, tick_irq}, 32'h0);
      step(1);
      check("rol_step", {24'b0, led}, {24'b0, rol_exp[k]});
      if (k == 0) check("rol_irq_post", {31'b0, tick_irq}, 32'h1);
    end

    // Rotate-right with wrap, PERIOD=2
    bus_write(32'h100, 32'h01);
    bus_write(32'h104, 32'd2);
    bus_write(32'h108, 32'd2);
    step(1);
    check("ror_wait", {24'b0, led}, 32'h01);
    step(1);
    check("ror_tick1", {24'b0, led}, 32'h80);
    step(1);
    check("ror_hold", {24'b0, led}, 32'h80);
    step(1);
    check("ror_tick2", {24'b0, led}, 32'h40);

    // Collision: an LED_DATA store in the tick cycle wins over the rotate
    bus_write(32'h104, 32'd1);
    step(1);
    bus_write(32'h100, 32'hA5);
    check("coll_led", {24'b0, led}, 32'hA5);
    step(1);
    check("coll_hold", {24'b0, led}, 32'hA5);
    step(1);
    check("coll_next", {24'b0, led}, 32'h4B);

    // W1C with no tick pending, then W1C in a tick cycle
    bus_write(32'h10C, 32'h1);
    check("w1c_irq", {31'b0, tick_irq}, 32'h0);
    bus_read(32'h10C, rd);
    check("w1c_status", rd, 32'h0);
    bus_write(32'h10C, 32'h1);
    check("w1c_tick_irq", {31'b0, tick_irq}, 32'h1);
    check("w1c_tick_led", {24'b0, led}, 32'h96);

    // Halt: PERIOD=0 stops ticks and rotation
    bus_write(32'h108, 32'd0);
    bus_write(32'h10C, 32'h1);
    step(200);
    check("halt_led", {24'b0, led}, 32'h96);
    check("halt_irq", {31'b0, tick_irq}, 32'h0);
    bus_read(32'h10C, rd);
    check("halt_status", rd, 32'h0);

    // Blink, PERIOD=2
    bus_write(32'h108, 32'd2);
    bus_write(32'h104, 32'd3);
    step(1);
    check("blink_on", {24'b0, led}, 32'h96);
    step(1);
    check("blink_off", {24'b0, led}, 32'h00);
    step(2);
    check("blink_on2", {24'b0, led}, 32'h96);

    // Decode and integration
    we = 1'b1; addr = 32'h64; wdata = 32'h19;
    #1;
    check("out_hit", {31'b0, hit}, 32'h0);
    check("out_dmem_we", {31'b0, dmem_we}, 32'h1);
    check("out_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0; addr = '0; wdata = '0;
    bus_read(32'h100, rd);
    check("out_led_reg", rd, 32'h96);

    we = 1'b1; addr = 32'h104; wdata = 32'h0;
    #1;
    check("in_hit", {31'b0, hit}, 32'h1);
    check("in_dmem_we", {31'b0, dmem_we}, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0; addr = '0; wdata = '0;
    bus_read(32'h107, rd);
    check("mode_rd", rd, 32'h0);
    check("mode_led", {24'b0, led}, 32'h96);

    addr = 32'h110;
    #1;
    check("ld110_hit", {31'b0, hit}, 32'h0);
    check("ld110_rdata", rdata, 32'h0);
    addr = '0;

    // Asynchronous reset in mid-count
    bus_write(32'h104, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_led", {24'b0, led}, 32'h01);
    check("arst_irq", {31'b0, tick_irq}, 32'h0);
    bus_read(32'h104, rd);
    check("arst_mode", rd, 32'h0);
    bus_read(32'h108, rd);
    check("arst_period", rd, 32'd50);
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
